// File: rtl/axi_slave_mem.sv
// AXI4 subordinate backed by a word-addressed RAM; independent read/write channels,
// one outstanding transaction each, FIXED/INCR bursts up to 256 beats.
module axi_slave_mem #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              S_AXI_awid,
    input  logic [31:0]             S_AXI_awaddr,
    input  logic [7:0]              S_AXI_awlen,
    input  logic [2:0]              S_AXI_awsize,
    input  logic [1:0]              S_AXI_awburst,
    input  logic                    S_AXI_awlock,
    input  logic [3:0]              S_AXI_awcache,
    input  logic [2:0]              S_AXI_awprot,
    input  logic [3:0]              S_AXI_awqos,
    input  logic [3:0]              S_AXI_awregion,
    input  logic                    S_AXI_awuser,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wlast,
    input  logic                    S_AXI_wuser,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [3:0]              S_AXI_bid,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_buser,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [3:0]              S_AXI_arid,
    input  logic [31:0]             S_AXI_araddr,
    input  logic [7:0]              S_AXI_arlen,
    input  logic [2:0]              S_AXI_arsize,
    input  logic [1:0]              S_AXI_arburst,
    input  logic                    S_AXI_arlock,
    input  logic [3:0]              S_AXI_arcache,
    input  logic [2:0]              S_AXI_arprot,
    input  logic [3:0]              S_AXI_arqos,
    input  logic [3:0]              S_AXI_arregion,
    input  logic                    S_AXI_aruser,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [3:0]              S_AXI_rid,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rlast,
    output logic                    S_AXI_ruser,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF_LSB    = $clog2(STRB_WIDTH);
    localparam logic [2:0]  MAX_SIZE   = 3'(OFF_LSB);
    localparam logic [32:0] MEM_BYTES  = 33'(64'(1) << (MEM_ADDR_WIDTH + OFF_LSB));
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

    // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return {1'b0, off} < MEM_BYTES;
    endfunction

    function automatic logic [MEM_ADDR_WIDTH-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return MEM_ADDR_WIDTH'(off >> OFF_LSB);
    endfunction

    function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b00 || burst == 2'b01) && size <= MAX_SIZE;
    endfunction

    // ---------------- write channel ----------------
    w_state_e        w_state_q, w_state_d;
    logic            awready_q, wready_q, bvalid_q;
    logic [3:0]      bid_q;
    logic [1:0]      bresp_q;
    logic [31:0]     w_addr_q;
    logic [7:0]      w_len_q, w_cnt_q;
    logic [2:0]      w_size_q;
    logic            w_fixed_q, w_ok_q, w_err_q;
    logic            aw_hs, w_hs, w_final, w_in_range, w_do_write, w_beat_err;
    logic [DATA_WIDTH-1:0] w_mask;

    assign aw_hs      = S_AXI_awvalid & awready_q;
    assign w_hs       = S_AXI_wvalid & wready_q;
    assign w_final    = (w_cnt_q == w_len_q);
    assign w_in_range = in_range(w_addr_q);
    assign w_do_write = w_hs & w_ok_q & w_in_range & ~rst;
    assign w_beat_err = ~w_ok_q | ~w_in_range | (S_AXI_wlast != w_final);

    for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_mask
        assign w_mask[8*b +: 8] = {8{S_AXI_wstrb[b]}};
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle: if (aw_hs) w_state_d = WData;
            WData: if (w_hs && w_final) w_state_d = WResp;
            WResp: if (bvalid_q && S_AXI_bready) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_fixed_q <= 1'b0;
            w_ok_q    <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == WIdle);
            wready_q  <= (w_state_d == WData);
            bvalid_q  <= (w_state_d == WResp);
            if (aw_hs) begin
                bid_q     <= S_AXI_awid;
                bresp_q   <= RESP_OKAY;
                w_addr_q  <= S_AXI_awaddr;
                w_len_q   <= S_AXI_awlen;
                w_size_q  <= S_AXI_awsize;
                w_fixed_q <= (S_AXI_awburst == 2'b00);
                w_ok_q    <= burst_ok(S_AXI_awburst, S_AXI_awsize);
                w_cnt_q   <= '0;
                w_err_q   <= 1'b0;
            end
            if (w_hs) begin
                w_cnt_q <= w_cnt_q + 8'd1;
                if (!w_fixed_q) w_addr_q <= w_addr_q + (32'd1 << w_size_q);
                if (w_beat_err) w_err_q <= 1'b1;
                if (w_final) bresp_q <= (w_err_q | w_beat_err) ? RESP_SLV : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            mem[word_idx(w_addr_q)] <= (mem[word_idx(w_addr_q)] & ~w_mask)
                                     | (S_AXI_wdata & w_mask);
        end
    end

    // ---------------- read channel ----------------
    r_state_e        r_state_q, r_state_d;
    logic            arready_q, rvalid_q, rlast_q;
    logic [3:0]      rid_q;
    logic [1:0]      rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [31:0]     r_addr_q, r_next_addr, fetch_addr;
    logic [7:0]      r_len_q, r_cnt_q;
    logic [2:0]      r_size_q;
    logic            r_fixed_q, r_ok_q;
    logic            ar_hs, r_hs, r_adv, fetch, fetch_good;

    assign ar_hs       = S_AXI_arvalid & arready_q;
    assign r_hs        = rvalid_q & S_AXI_rready;
    assign r_adv       = r_hs & ~rlast_q;
    assign fetch       = ar_hs | r_adv;
    assign r_next_addr = r_fixed_q ? r_addr_q : r_addr_q + (32'd1 << r_size_q);
    assign fetch_addr  = ar_hs ? S_AXI_araddr : r_next_addr;
    assign fetch_good  = (ar_hs ? burst_ok(S_AXI_arburst, S_AXI_arsize) : r_ok_q)
                       & in_range(fetch_addr);

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle: if (ar_hs) r_state_d = RData;
            RData: if (r_hs && rlast_q) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_fixed_q <= 1'b0;
            r_ok_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == RIdle);
            rvalid_q  <= (r_state_d == RData);
            if (ar_hs) begin
                rid_q     <= S_AXI_arid;
                r_addr_q  <= S_AXI_araddr;
                r_len_q   <= S_AXI_arlen;
                r_size_q  <= S_AXI_arsize;
                r_fixed_q <= (S_AXI_arburst == 2'b00);
                r_ok_q    <= burst_ok(S_AXI_arburst, S_AXI_arsize);
                r_cnt_q   <= '0;
                rlast_q   <= (S_AXI_arlen == 8'd0);
            end else if (r_adv) begin
                r_cnt_q  <= r_cnt_q + 8'd1;
                r_addr_q <= r_next_addr;
                rlast_q  <= (r_cnt_q + 8'd1 == r_len_q);
            end else if (r_hs) begin
                rlast_q <= 1'b0;
            end
            // Read-before-write: a same-cycle write to this word lands after this sample.
            if (fetch) begin
                rdata_q <= fetch_good ? mem[word_idx(fetch_addr)] : '0;
                rresp_q <= fetch_good ? RESP_OKAY : RESP_SLV;
            end
        end
    end

    assign S_AXI_awready = awready_q;
    assign S_AXI_wready  = wready_q;
    assign S_AXI_bvalid  = bvalid_q;
    assign S_AXI_bid     = bid_q;
    assign S_AXI_bresp   = bresp_q;
    assign S_AXI_buser   = 1'b0;
    assign S_AXI_arready = arready_q;
    assign S_AXI_rvalid  = rvalid_q;
    assign S_AXI_rid     = rid_q;
    assign S_AXI_rdata   = rdata_q;
    assign S_AXI_rresp   = rresp_q;
    assign S_AXI_rlast   = rlast_q;
    assign S_AXI_ruser   = 1'b0;

    logic unused_sideband;
    assign unused_sideband = ^{S_AXI_awlock, S_AXI_awcache, S_AXI_awprot, S_AXI_awqos,
                               S_AXI_awregion, S_AXI_awuser, S_AXI_wuser, S_AXI_arlock,
                               S_AXI_arcache, S_AXI_arprot, S_AXI_arqos, S_AXI_arregion,
                               S_AXI_aruser};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: one task per scenario.
module tb_axi_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  S_AXI_awid;
    logic [31:0] S_AXI_awaddr;
    logic [7:0]  S_AXI_awlen;
    logic [2:0]  S_AXI_awsize;
    logic [1:0]  S_AXI_awburst;
    logic        S_AXI_awvalid, S_AXI_awready;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wlast, S_AXI_wvalid, S_AXI_wready;
    logic [3:0]  S_AXI_bid;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_buser, S_AXI_bvalid, S_AXI_bready;
    logic [3:0]  S_AXI_arid;
    logic [31:0] S_AXI_araddr;
    logic [7:0]  S_AXI_arlen;
    logic [2:0]  S_AXI_arsize;
    logic [1:0]  S_AXI_arburst;
    logic        S_AXI_arvalid, S_AXI_arready;
    logic [3:0]  S_AXI_rid;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rlast, S_AXI_ruser, S_AXI_rvalid, S_AXI_rready;

    axi_slave_mem #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_awid(S_AXI_awid), .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen),
        .S_AXI_awsize(S_AXI_awsize), .S_AXI_awburst(S_AXI_awburst), .S_AXI_awlock(1'b0),
        .S_AXI_awcache(4'h0), .S_AXI_awprot(3'h0), .S_AXI_awqos(4'h0),
        .S_AXI_awregion(4'h0), .S_AXI_awuser(1'b0), .S_AXI_awvalid(S_AXI_awvalid),
        .S_AXI_awready(S_AXI_awready), .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
        .S_AXI_wlast(S_AXI_wlast), .S_AXI_wuser(1'b0), .S_AXI_wvalid(S_AXI_wvalid),
        .S_AXI_wready(S_AXI_wready), .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp),
        .S_AXI_buser(S_AXI_buser), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
        .S_AXI_arid(S_AXI_arid), .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen),
        .S_AXI_arsize(S_AXI_arsize), .S_AXI_arburst(S_AXI_arburst), .S_AXI_arlock(1'b0),
        .S_AXI_arcache(4'h0), .S_AXI_arprot(3'h0), .S_AXI_arqos(4'h0),
        .S_AXI_arregion(4'h0), .S_AXI_aruser(1'b0), .S_AXI_arvalid(S_AXI_arvalid),
        .S_AXI_arready(S_AXI_arready), .S_AXI_rid(S_AXI_rid), .S_AXI_rdata(S_AXI_rdata),
        .S_AXI_rresp(S_AXI_rresp), .S_AXI_rlast(S_AXI_rlast), .S_AXI_ruser(S_AXI_ruser),
        .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [1:0]  b_resp;
    logic [3:0]  b_id, r_id;
    logic        rv_after_ar;

    // Drivers: inputs change 1 time unit after posedge; outputs sampled at the same point.
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        logic hs = 1'b0;
        S_AXI_awid = id; S_AXI_awaddr = addr; S_AXI_awlen = len;
        S_AXI_awsize = size; S_AXI_awburst = burst; S_AXI_awvalid = 1'b1;
        for (int k = 0; k < 100 && !hs; k++) begin
            hs = S_AXI_awready;
            @(posedge clk); #1;
        end
        S_AXI_awvalid = 1'b0;
        if (!hs) begin
            n_cmp++; n_err++;
            $display("FAIL aw_timeout: awready stayed 0, required 1");
        end
    endtask

    task automatic do_w(input int n, input int last_idx, input bit thr);
        for (int i = 0; i < n; i++) begin
            logic hs = 1'b0;
            if (thr) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            S_AXI_wdata = wbuf[i]; S_AXI_wstrb = sbuf[i];
            S_AXI_wlast = (i == last_idx); S_AXI_wvalid = 1'b1;
            for (int k = 0; k < 100 && !hs; k++) begin
                hs = S_AXI_wready;
                @(posedge clk); #1;
            end
            S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
            if (!hs) begin
                n_cmp++; n_err++;
                $display("FAIL w_timeout: beat %0d wready stayed 0, required 1", i);
                break;
            end
        end
    endtask

    task automatic do_b();
        logic hs = 1'b0;
        b_resp = 2'bxx; b_id = 4'hx;
        S_AXI_bready = 1'b1;
        for (int k = 0; k < 100 && !hs; k++) begin
            hs = S_AXI_bvalid;
            if (hs) begin b_resp = S_AXI_bresp; b_id = S_AXI_bid; end
            @(posedge clk); #1;
        end
        S_AXI_bready = 1'b0;
        if (!hs) begin
            n_cmp++; n_err++;
            $display("FAIL b_timeout: bvalid stayed 0, required 1");
        end
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        logic hs = 1'b0;
        S_AXI_arid = id; S_AXI_araddr = addr; S_AXI_arlen = len;
        S_AXI_arsize = size; S_AXI_arburst = burst; S_AXI_arvalid = 1'b1;
        for (int k = 0; k < 100 && !hs; k++) begin
            hs = S_AXI_arready;
            @(posedge clk); #1;
        end
        S_AXI_arvalid = 1'b0;
        rv_after_ar = S_AXI_rvalid;
        if (!hs) begin
            n_cmp++; n_err++;
            $display("FAIL ar_timeout: arready stayed 0, required 1");
        end
    endtask

    task automatic do_r(input int n, input bit thr);
        int got = 0;
        for (int k = 0; k < 2000 && got < n; k++) begin
            S_AXI_rready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (S_AXI_rvalid && S_AXI_rready) begin
                rd_data[got] = S_AXI_rdata; rd_resp[got] = S_AXI_rresp;
                rd_last[got] = S_AXI_rlast; r_id = S_AXI_rid;
                got++;
            end
            @(posedge clk); #1;
        end
        S_AXI_rready = 1'b0;
        if (got < n) begin
            n_cmp++; n_err++;
            $display("FAIL r_timeout: got %0d beats, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({S_AXI_awready, S_AXI_arready, S_AXI_wready, S_AXI_bvalid, S_AXI_rvalid,
             S_AXI_rlast, S_AXI_bresp, S_AXI_rresp, S_AXI_bid, S_AXI_rid, S_AXI_rdata,
             S_AXI_buser, S_AXI_ruser} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({S_AXI_awready, S_AXI_arready, S_AXI_wready, S_AXI_bvalid, S_AXI_rvalid} !==
            5'b11000) begin
            n_err++;
            $display("FAIL reset_release: aw/ar/w/b/r = %b, required 11000",
                     {S_AXI_awready, S_AXI_arready, S_AXI_wready, S_AXI_bvalid, S_AXI_rvalid});
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_aw(4'h3, 32'h10, 8'd0, 3'd2, INCR);
        do_w(1, 0, 1'b0);
        do_b();
        n_cmp++;
        if (b_resp !== 2'b00) begin n_err++; $display("FAIL single_bresp: got %b, required 00", b_resp); end
        n_cmp++;
        if (b_id !== 4'h3) begin n_err++; $display("FAIL single_bid: got %h, required 3", b_id); end
        n_cmp++;
        if (S_AXI_awready !== 1'b1) begin n_err++; $display("FAIL single_awready_back: got %b, required 1", S_AXI_awready); end
        do_ar(4'h5, 32'h10, 8'd0, 3'd2, INCR);
        n_cmp++;
        if (rv_after_ar !== 1'b1) begin n_err++; $display("FAIL single_latency: rvalid %b one cycle after AR, required 1", rv_after_ar); end
        do_r(1, 1'b0);
        n_cmp++;
        if ({rd_data[0], rd_resp[0], rd_last[0], r_id} !== {32'hDEADBEEF, 2'b00, 1'b1, 4'h5}) begin
            n_err++;
            $display("FAIL single_read: data %h resp %b last %b id %h, required deadbeef 00 1 5",
                     rd_data[0], rd_resp[0], rd_last[0], r_id);
        end
        n_cmp++;
        if (S_AXI_rvalid !== 1'b0) begin n_err++; $display("FAIL single_rvalid_drop: got %b, required 0", S_AXI_rvalid); end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_aw(4'h1, 32'h100, 8'd7, 3'd2, INCR);
        do_w(8, 7, 1'b1);
        do_b();
        n_cmp++;
        if (b_resp !== 2'b00) begin n_err++; $display("FAIL incr_bresp: got %b, required 00", b_resp); end
        do_ar(4'h2, 32'h100, 8'd7, 3'd2, INCR);
        do_r(8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'(i + 1), 2'b00, (i == 7)}) begin
                n_err++;
                $display("FAIL incr_beat%0d: data %h resp %b last %b, required %h 00 %b",
                         i, rd_data[i], rd_resp[i], rd_last[i], i + 1, i == 7);
            end
        end
    endtask

    task automatic test_fixed_strobe();
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_aw(4'h0, 32'h20, 8'd0, 3'd2, INCR); do_w(1, 0, 1'b0); do_b();
        wbuf[0] = 32'h000000AA; sbuf[0] = 4'b0001;
        wbuf[1] = 32'h0000BB00; sbuf[1] = 4'b0010;
        do_aw(4'h4, 32'h20, 8'd1, 3'd2, FIXED); do_w(2, 1, 1'b0); do_b();
        n_cmp++;
        if (b_resp !== 2'b00) begin n_err++; $display("FAIL fixed_bresp: got %b, required 00", b_resp); end
        do_ar(4'h4, 32'h20, 8'd0, 3'd2, INCR); do_r(1, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 32'h1122BBAA) begin n_err++; $display("FAIL fixed_strobe: got %h, required 1122bbaa", rd_data[0]); end
    endtask

    task automatic test_errors();
        wbuf[0] = 32'hCAFEF00D; wbuf[1] = 32'h0BADC0DE; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_aw(4'h0, 32'h200, 8'd1, 3'd2, INCR); do_w(2, 1, 1'b0); do_b();
        wbuf[0] = 32'h55555555; wbuf[1] = 32'h55555555;
        do_aw(4'h8, 32'h200, 8'd1, 3'd2, WRAP); do_w(2, 1, 1'b0); do_b();
        n_cmp++;
        if (b_resp !== 2'b10) begin n_err++; $display("FAIL wrap_bresp: got %b, required 10", b_resp); end
        do_ar(4'h0, 32'h200, 8'd1, 3'd2, INCR); do_r(2, 1'b0);
        n_cmp++;
        if ({rd_data[0], rd_data[1]} !== {32'hCAFEF00D, 32'h0BADC0DE}) begin
            n_err++;
            $display("FAIL wrap_ram_kept: got %h %h, required cafef00d 0badc0de", rd_data[0], rd_data[1]);
        end
        do_ar(4'hA, 32'h1000, 8'd3, 3'd2, INCR); do_r(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'h0, 2'b10, (i == 3)}) begin
                n_err++;
                $display("FAIL oob_beat%0d: data %h resp %b last %b, required 0 10 %b",
                         i, rd_data[i], rd_resp[i], rd_last[i], i == 3);
            end
        end
        do_ar(4'hB, 32'h100, 8'd1, 3'd3, INCR); do_r(2, 1'b0);
        n_cmp++;
        if ({rd_data[0], rd_resp[0], rd_data[1], rd_resp[1], rd_last[1]} !==
            {32'h0, 2'b10, 32'h0, 2'b10, 1'b1}) begin
            n_err++;
            $display("FAIL size_err_read: resp %b %b data %h %h, required 10 10 0 0",
                     rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
        end
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h300 + 32'(i); sbuf[i] = 4'hF; end
        do_aw(4'hC, 32'h300, 8'd3, 3'd2, INCR); do_w(4, 1, 1'b0); do_b();
        n_cmp++;
        if (b_resp !== 2'b10) begin n_err++; $display("FAIL wlast_bresp: got %b, required 10", b_resp); end
        do_ar(4'hC, 32'h300, 8'd3, 3'd2, INCR); do_r(4, 1'b0);
        n_cmp++;
        if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !==
            {32'h300, 32'h301, 32'h302, 32'h303}) begin
            n_err++;
            $display("FAIL wlast_data: got %h %h %h %h, required 300 301 302 303",
                     rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
        fork
            begin do_aw(4'h6, 32'h400, 8'd3, 3'd2, INCR); do_w(4, 3, 1'b1); do_b(); end
            begin do_ar(4'h7, 32'h100, 8'd7, 3'd2, INCR); do_r(8, 1'b1); end
        join
        n_cmp++;
        if ({b_resp, b_id} !== {2'b00, 4'h6}) begin n_err++; $display("FAIL conc_b: resp %b id %h, required 00 6", b_resp, b_id); end
        n_cmp++;
        if ({rd_data[0], rd_data[7], rd_last[7], r_id} !== {32'd1, 32'd8, 1'b1, 4'h7}) begin
            n_err++;
            $display("FAIL conc_read: first %h last %h rlast %b id %h, required 1 8 1 7",
                     rd_data[0], rd_data[7], rd_last[7], r_id);
        end
        do_ar(4'h7, 32'h400, 8'd3, 3'd2, INCR); do_r(4, 1'b0);
        n_cmp++;
        if ({rd_data[0], rd_data[3]} !== {32'hA0, 32'hA3}) begin
            n_err++;
            $display("FAIL conc_write: got %h %h, required a0 a3", rd_data[0], rd_data[3]);
        end
    endtask

    task automatic test_bready_hold();
        wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
        do_aw(4'h9, 32'h500, 8'd0, 3'd2, INCR); do_w(1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({S_AXI_bvalid, S_AXI_awready} !== 2'b10) begin
                n_err++;
                $display("FAIL bhold_cycle%0d: bvalid/awready %b, required 10", i,
                         {S_AXI_bvalid, S_AXI_awready});
            end
            @(posedge clk); #1;
        end
        do_b();
        n_cmp++;
        if ({b_resp, b_id, S_AXI_awready} !== {2'b00, 4'h9, 1'b1}) begin
            n_err++;
            $display("FAIL bhold_release: resp %b id %h awready %b, required 00 9 1",
                     b_resp, b_id, S_AXI_awready);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h60 + 32'(i); sbuf[i] = 4'hF; end
        do_aw(4'h2, 32'h600, 8'd7, 3'd2, INCR); do_w(8, 7, 1'b0); do_b();
        do_ar(4'hD, 32'h600, 8'd7, 3'd2, INCR);
        S_AXI_rready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if ({S_AXI_rvalid, S_AXI_rdata} !== {1'b1, 32'h62}) begin
            n_err++;
            $display("FAIL rstmid_beat3: rvalid %b data %h, required 1 62", S_AXI_rvalid, S_AXI_rdata);
        end
        rst = 1'b1; S_AXI_rready = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({S_AXI_rvalid, S_AXI_arready, S_AXI_awready, S_AXI_rlast, S_AXI_rdata} !== '0) begin
            n_err++;
            $display("FAIL rstmid_in_reset: rvalid %b arready %b awready %b rdata %h, required 0 0 0 0",
                     S_AXI_rvalid, S_AXI_arready, S_AXI_awready, S_AXI_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({S_AXI_arready, S_AXI_awready, S_AXI_rvalid} !== 3'b110) begin
            n_err++;
            $display("FAIL rstmid_release: arready/awready/rvalid %b, required 110",
                     {S_AXI_arready, S_AXI_awready, S_AXI_rvalid});
        end
        do_ar(4'hE, 32'h604, 8'd1, 3'd2, INCR); do_r(2, 1'b0);
        n_cmp++;
        if ({rd_data[0], rd_data[1], rd_last[1], r_id} !== {32'h61, 32'h62, 1'b1, 4'hE}) begin
            n_err++;
            $display("FAIL rstmid_new_read: %h %h last %b id %h, required 61 62 1 e",
                     rd_data[0], rd_data[1], rd_last[1], r_id);
        end
    endtask

    initial begin
        rst = 1'b1;
        S_AXI_awid = '0; S_AXI_awaddr = '0; S_AXI_awlen = '0; S_AXI_awsize = '0;
        S_AXI_awburst = '0; S_AXI_awvalid = 1'b0;
        S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wlast = 1'b0; S_AXI_wvalid = 1'b0;
        S_AXI_bready = 1'b0;
        S_AXI_arid = '0; S_AXI_araddr = '0; S_AXI_arlen = '0; S_AXI_arsize = '0;
        S_AXI_arburst = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;
        test_reset();
        test_single();
        test_incr();
        test_fixed_strobe();
        test_errors();
        test_concurrent();
        test_bready_hold();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish within 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI4 full-protocol memory responder with a word-addressed internal RAM.
- It is the subordinate end of the interface driven by AXI_master.
- It replaces the BFM slave in standalone and regression benches, and serves as a synthesizable scratch memory in the block design.
- Write and read channels are independent; each channel has one outstanding transaction. The block supports FIXED and INCR bursts of up to 256 beats.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; legal values are 32 and 64.
- MEM_ADDR_WIDTH, 10, log2 of the RAM depth in DATA_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be aligned to the RAM size.

Ports:
- clk  in  1  Clock for all logic.
- rst  in  1  Synchronous reset, active-high.
- S_AXI_awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  Write address channel.
- S_AXI_awlock/awcache/awprot/awqos/awregion/awuser  in  1/4/3/4/4/1  Accepted and ignored.
- S_AXI_awvalid  in  1  Write address valid.
- S_AXI_awready  out  1  Write address ready.
- S_AXI_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  Write data channel.
- S_AXI_wuser  in  1  Ignored.
- S_AXI_wvalid  in  1  Write data valid.
- S_AXI_wready  out  1  Write data ready.
- S_AXI_bid/bresp  out  4/2  Write response ID and response code.
- S_AXI_buser  out  1  Tied to 0.
- S_AXI_bvalid  out  1  Write response valid.
- S_AXI_bready  in  1  Write response ready.
- S_AXI_arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  Read address channel.
- S_AXI_arlock/arcache/arprot/arqos/arregion/aruser  in  1/4/3/4/4/1  Accepted and ignored.
- S_AXI_arvalid  in  1  Read address valid.
- S_AXI_arready  out  1  Read address ready.
- S_AXI_rid/rdata/rresp/rlast  out  4/DATA_WIDTH/2/1  Read data channel.
- S_AXI_ruser  out  1  Tied to 0.
- S_AXI_rvalid  out  1  Read data valid.
- S_AXI_rready  in  1  Read data ready.

Behaviour:
- Reset: all outputs are 0 while rst=1, including awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid and rdata. RAM contents are not cleared. In the first cycle after rst falls, awready=1 and arready=1.
- All outputs are driven from registers; there are no combinational input-to-output paths.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, latch id, addr, len, size and burst; clear the error flag and beat counter; go to W_DATA, with awready=0 and wready=1 from the next cycle.
  - W_DATA: each wvalid&wready is one beat. If the beat address is in range and the burst is legal, write the RAM with per-byte wstrb enables. Address update: INCR adds 2^size bytes; FIXED keeps the address.
  - W_DATA end of burst: on beat awlen+1, wready drops and the FSM goes to W_RESP with bvalid=1 in the next cycle. An early wlast, or a missing wlast on the final beat, sets SLVERR but does not terminate the burst.
  - W_RESP: bid equals the latched awid. Hold bvalid until bready, then return to W_IDLE, with awready=1 the next cycle.
  - bresp codes: OKAY=00; SLVERR=10 if any error was flagged during the burst.
- Write error conditions, each of which gives SLVERR:
  - burst=WRAP or 2'b11; no beats are written.
  - 2^size greater than DATA_WIDTH/8; no beats are written.
  - A beat address outside BASE_ADDR plus the RAM size; only that beat is dropped.
  - wlast mismatch, as described under W_DATA.
- Read FSM states are R_IDLE and R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch the request and read RAM[addr]. In the next cycle rvalid=1 and rdata is valid, so the first-beat latency is 1 cycle.
  - R_DATA: rdata, rresp and rlast hold stable while rvalid&!rready. On each rvalid&rready, fetch the next beat so that it is presented the next cycle; back-to-back beats run at full throughput.
  - rlast=1 on beat arlen+1. After that handshake, rvalid=0 and the FSM returns to R_IDLE.
  - rid equals the latched arid.
- rresp is reported per beat:
  - Out-of-range beat: SLVERR, rdata=0.
  - Illegal burst type or size: every beat is SLVERR with rdata=0, and the beat count is still honoured.
- Narrow transfers:
  - The word index is (addr-BASE_ADDR)>>log2(DATA_WIDTH/8).
  - Reads return the full word; writes rely on the master's wstrb.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-before-write).
- Reset mid-burst: both FSMs return to idle with all outputs zero. Partially written beats remain in RAM.
- INCR address arithmetic is 32-bit with no 4KB wrap; crossing the RAM end gives SLVERR on the out-of-range beats.

Test Plan:
- Single write then single read: awaddr=0x10, len=0, wdata=0xDEADBEEF, wstrb=F. Required: bresp=00. A read of 0x10 returns 0xDEADBEEF with rlast=1 and rresp=00, with rvalid exactly 1 cycle after the AR handshake.
- INCR burst: 8 beats (len=7, size=2) at 0x100 with data 1..8, then an 8-beat read. Required: data returns 1..8 in order and rlast is asserted only on beat 8. A random rready/wvalid throttle must not change the results.
- FIXED burst and strobes: write 0x000000AA (wstrb=0001) then 0x0000BB00 (wstrb=0010) to 0x20 with burst=FIXED. Required: a read returns 0x0000BBAA in the low bytes, with the upper bytes keeping their prior value.
- Errors:
  - A WRAP write must return bresp=10 and leave RAM unchanged.
  - A read at BASE_ADDR+4096 with len=3 returns 4 beats, each with rresp=10 and rdata=0.
  - A write with wlast asserted on beat 2 of 4 returns bresp=10 after 4 beats.
- Concurrency and backpressure:
  - With the read and write channels active simultaneously on different addresses, both complete correctly.
  - With bready held low for 10 cycles, bvalid stays high and awready=0 throughout.
- Reset mid-burst: assert rst at beat 3 of an 8-beat read. Required: the next cycle shows rvalid=0, arready=0 and awready=0. One cycle after rst is released, arready=1, and a new read completes normally.
